// File: rtl/dvi_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dvi_pkg
// Description : Shared TMDS definitions: the four control tokens, the
//               alignment FSM state type and a token-match helper.
// Revision    : 1.0 - initial release
// ============================================================================
package dvi_pkg;

  localparam logic [9:0] DVI_CTL0 = 10'b1101010100;
  localparam logic [9:0] DVI_CTL1 = 10'b0010101011;
  localparam logic [9:0] DVI_CTL2 = 10'b0101010100;
  localparam logic [9:0] DVI_CTL3 = 10'b1010101011;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    SEARCH = 3'd1,
    SLIP   = 3'd2,
    SETTLE = 3'd3,
    LOCKED = 3'd4
  } dvi_align_st_t;

  // True when a raw 10-bit word is one of the four control tokens.
  function automatic logic is_ctl_token(input logic [9:0] word);
    return (word == DVI_CTL0) || (word == DVI_CTL1) ||
           (word == DVI_CTL2) || (word == DVI_CTL3);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dvi_token_det.sv
`default_nettype none
// ============================================================================
// Module      : dvi_token_det
// Description : Registered TMDS control-token detector. The flag lags the
//               raw word by one clock; the data decoder can share it.
// Revision    : 1.0 - initial release
// ============================================================================
module dvi_token_det
  import dvi_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [9:0] ch_in,
  output logic       tok_r
);

  // Register the token comparison of the incoming word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) tok_r <= 1'b0;
    else        tok_r <= is_ctl_token(ch_in);
  end

endmodule
`default_nettype wire

// File: rtl/dvi_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : dvi_align_ctrl
// Description : TMDS word-alignment controller for one DVI channel. Counts
//               control tokens per window, requests bit slips until the
//               token rate is met, then holds lock and watches for loss.
//               Optional lock-loss counter on err_cnt when the macro
//               DVI_ALIGN_STAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module dvi_align_ctrl
  import dvi_pkg::*;
#(
  parameter int SEARCH_LEN = 1024,
  parameter int TOKEN_MIN  = 16,
  parameter int SETTLE_LEN = 8,
  parameter int LOSS_MAX   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [9:0]  ch_in,
  input  logic        en,
  output logic        bitslip,
  output logic        locked,
  output logic        token_det,
  output logic [3:0]  slip_cnt
`ifdef DVI_ALIGN_STAT_EN
  ,
  output logic [15:0] err_cnt
`endif
);

  localparam int WIN_W  = $clog2(SEARCH_LEN + 1);
  localparam int TOK_W  = $clog2(TOKEN_MIN + 1);
  localparam int SET_W  = $clog2(SETTLE_LEN + 1);
  localparam int MISS_W = $clog2(LOSS_MAX + 1);

  dvi_align_st_t     state, next_state;
  logic [WIN_W-1:0]  win_cnt;
  logic [TOK_W-1:0]  tok_cnt;
  logic [SET_W-1:0]  set_cnt;
  logic [MISS_W-1:0] miss_cnt;
  logic              tok_r;
  logic              win_last;
  logic              win_good;
  logic              settle_done;
  logic              miss_last;

  dvi_token_det u_token_det (
    .clk   (clk),
    .rst_n (rst_n),
    .ch_in (ch_in),
    .tok_r (tok_r)
  );

  assign token_det = tok_r;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state decode; the window verdict includes this cycle's token.
  always_comb begin
    next_state  = state;
    win_last    = (win_cnt == WIN_W'(SEARCH_LEN - 1));
    win_good    = (tok_cnt == TOK_W'(TOKEN_MIN)) ||
                  (tok_r && (tok_cnt == TOK_W'(TOKEN_MIN - 1)));
    settle_done = (set_cnt == SET_W'(SETTLE_LEN - 1));
    miss_last   = (miss_cnt == MISS_W'(LOSS_MAX - 1));
    if (!en) begin
      next_state = IDLE;
    end else begin
      case (state)
        IDLE:    next_state = SEARCH;
        SEARCH:  if (win_last) next_state = win_good ? LOCKED : SLIP;
        SLIP:    next_state = SETTLE;
        SETTLE:  if (settle_done) next_state = SEARCH;
        LOCKED:  if (win_last && !win_good && miss_last) next_state = SEARCH;
        default: next_state = IDLE;
      endcase
    end
  end

  // Window, token, settle and miss counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_cnt  <= '0;
      tok_cnt  <= '0;
      set_cnt  <= '0;
      miss_cnt <= '0;
    end else begin
      if ((state == SEARCH || state == LOCKED) && !win_last) begin
        win_cnt <= win_cnt + WIN_W'(1);
        if (tok_r && (tok_cnt != TOK_W'(TOKEN_MIN)))
          tok_cnt <= tok_cnt + TOK_W'(1);
      end else begin
        win_cnt <= '0;
        tok_cnt <= '0;
      end

      if (state == SETTLE && next_state == SETTLE) set_cnt <= set_cnt + SET_W'(1);
      else                                         set_cnt <= '0;

      if (next_state != LOCKED)
        miss_cnt <= '0;
      else if (state == LOCKED && win_last)
        miss_cnt <= win_good ? '0 : miss_cnt + MISS_W'(1);
    end
  end

  // Registered outputs; decoding next_state lets en=0 drop them immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bitslip  <= 1'b0;
      locked   <= 1'b0;
      slip_cnt <= 4'd0;
    end else begin
      bitslip <= (next_state == SLIP);
      locked  <= (next_state == LOCKED);
      if (next_state == LOCKED && state != LOCKED)
        slip_cnt <= 4'd0;
      else if (state == SLIP)
        slip_cnt <= (slip_cnt == 4'd9) ? 4'd0 : slip_cnt + 4'd1;
    end
  end

`ifdef DVI_ALIGN_STAT_EN
  // Lock-loss counter, saturating; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= 16'd0;
    else if (state == LOCKED && next_state == SEARCH && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_dvi_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_dvi_align_ctrl
// Description : Self-checking bench for dvi_align_ctrl with a behavioural
//               reference model and directed scenarios. Honours the
//               DVI_ALIGN_STAT_EN macro for the err_cnt port.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dvi_align_ctrl;

  localparam int SEARCH_LEN = 16;
  localparam int TOKEN_MIN  = 4;
  localparam int SETTLE_LEN = 3;
  localparam int LOSS_MAX   = 2;

  localparam logic [9:0] T0 = 10'b1101010100;
  localparam logic [9:0] T1 = 10'b0010101011;
  localparam logic [9:0] T2 = 10'b0101010100;
  localparam logic [9:0] T3 = 10'b1010101011;

  localparam int PH_IDLE = 0, PH_SEARCH = 1, PH_SLIP = 2, PH_SETTLE = 3, PH_LOCKED = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [9:0] ch_in = 10'd0;
  logic       en = 1'b0;
  logic       bitslip, locked, token_det;
  logic [3:0] slip_cnt;
`ifdef DVI_ALIGN_STAT_EN
  logic [15:0] err_cnt;
`endif

  int checks = 0;
  int errors = 0;

  dvi_align_ctrl #(
    .SEARCH_LEN (SEARCH_LEN),
    .TOKEN_MIN  (TOKEN_MIN),
    .SETTLE_LEN (SETTLE_LEN),
    .LOSS_MAX   (LOSS_MAX)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ch_in     (ch_in),
    .en        (en),
    .bitslip   (bitslip),
    .locked    (locked),
    .token_det (token_det),
    .slip_cnt  (slip_cnt)
`ifdef DVI_ALIGN_STAT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_tok(input logic [9:0] w);
    logic [9:0] toks [4];
    toks[0] = T0; toks[1] = T1; toks[2] = T2; toks[3] = T3;
    for (int i = 0; i < 4; i++) if (w == toks[i]) return 1;
    return 0;
  endfunction

  // Reference model: phase plus age-in-phase, plain unsaturated token sum.
  int m_phase, m_age, m_sum, m_miss, m_tok, m_slips, m_errs;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= PH_IDLE; m_age <= 0; m_sum <= 0; m_miss <= 0;
      m_tok <= 0; m_slips <= 0; m_errs <= 0;
    end else begin
      m_tok <= model_tok(ch_in);
      if (m_phase == PH_SLIP) m_slips <= (m_slips + 1) % 10;
      if (!en) begin
        m_phase <= PH_IDLE; m_age <= 0; m_sum <= 0; m_miss <= 0;
      end else if (m_phase == PH_IDLE) begin
        m_phase <= PH_SEARCH; m_age <= 0; m_sum <= 0;
      end else if (m_phase == PH_SEARCH || m_phase == PH_LOCKED) begin
        if (m_age < SEARCH_LEN - 1) begin
          m_age <= m_age + 1; m_sum <= m_sum + m_tok;
        end else begin
          m_age <= 0; m_sum <= 0;
          if (m_phase == PH_SEARCH) begin
            if (m_sum + m_tok >= TOKEN_MIN) begin
              m_phase <= PH_LOCKED; m_slips <= 0; m_miss <= 0;
            end else m_phase <= PH_SLIP;
          end else if (m_sum + m_tok >= TOKEN_MIN) m_miss <= 0;
          else if (m_miss + 1 >= LOSS_MAX) begin
            m_phase <= PH_SEARCH; m_miss <= 0;
            m_errs <= (m_errs < 65535) ? m_errs + 1 : m_errs;
          end else m_miss <= m_miss + 1;
        end
      end else if (m_phase == PH_SLIP) begin
        m_phase <= PH_SETTLE; m_age <= 0;
      end else begin
        if (m_age >= SETTLE_LEN - 1) begin m_phase <= PH_SEARCH; m_age <= 0; end
        else m_age <= m_age + 1;
      end
    end
  end

  // Compare DUT outputs to the model on every falling edge.
  always @(negedge clk) begin
    chk("bitslip",   int'(bitslip),   int'(m_phase == PH_SLIP));
    chk("locked",    int'(locked),    int'(m_phase == PH_LOCKED));
    chk("token_det", int'(token_det), m_tok);
    chk("slip_cnt",  int'(slip_cnt),  m_slips);
`ifdef DVI_ALIGN_STAT_EN
    chk("err_cnt",   int'(err_cnt),   m_errs);
`endif
  end

  task automatic wait_bitslip(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bitslip && n < max);
    if (!bitslip) chk("bitslip_timeout", 0, 1);
  endtask

  task automatic wait_locked(input int max, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!locked && n < max);
    if (!locked) chk("locked_timeout", 0, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    // Reset held with random words and en high: everything stays zero.
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      ch_in = 10'($urandom);
      chk("rst_out", int'({bitslip, locked, token_det, slip_cnt}), 0);
    end
    @(negedge clk);
    rst_n = 1'b1; en = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      ch_in = (i < 3) ? 10'($urandom) : 10'd0;
      chk("idle_locked", int'(locked), 0);
    end

    // Constant token: detect one cycle later, lock after the first window.
    ch_in = T0; en = 1'b1;
    @(negedge clk);
    chk("tok_lag", int'(token_det), 1);
    wait_locked(40, n);
    chk("lock_latency", n, 16);
    chk("lock_slip_cnt", int'(slip_cnt), 0);
    en = 1'b0; ch_in = 10'd0;
    @(negedge clk);
    chk("en_drop_unlock", int'(locked), 0);
    en = 1'b1;

    // No tokens: a slip every 20 cycles, slip_cnt modulo 10.
    for (int k = 1; k <= 11; k++) begin
      wait_bitslip(40, n);
      chk("slip_period", n, (k == 1) ? 17 : 19);
      @(negedge clk);
      chk("slip_width", int'(bitslip), 0);
      chk("slip_count", int'(slip_cnt), k % 10);
    end

    // Now in SETTLE: drop en, no further slips, count retained.
    en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_no_slip", int'(bitslip), 0);
    end
    chk("slip_retained", int'(slip_cnt), 1);

    // Window with 3 tokens slips; next window with 4 tokens locks.
    en = 1'b1; ch_in = 10'd0;
    for (int k = 1; k <= 37; k++) begin
      @(negedge clk);
      ch_in = (k <= 3) ? T1 : (k >= 23 && k <= 26) ? T3 : 10'd0;
      if (k == 16) chk("w3_no_slip_yet", int'(bitslip), 0);
      if (k == 17) chk("w3_slip", int'(bitslip), 1);
      if (k == 18) chk("w3_slip_cnt", int'(slip_cnt), 2);
      if (k == 36) chk("w4_not_locked", int'(locked), 0);
      if (k == 37) begin
        chk("w4_locked", int'(locked), 1);
        chk("w4_slip_clr", int'(slip_cnt), 0);
      end
    end

    // Tokens stop: unlock after two bad windows; then en falls on a window end.
    for (int m = 1; m <= 52; m++) begin
      @(negedge clk);
      if (m == 48) en = 1'b0;
      if (m == 31) chk("loss_still_locked", int'(locked), 1);
      if (m == 32) begin
        chk("loss_unlock", int'(locked), 0);
`ifdef DVI_ALIGN_STAT_EN
        chk("loss_err_cnt", int'(err_cnt), 1);
`endif
      end
      if (m >= 49) chk("en_wins_no_slip", int'(bitslip), 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dvi_align_ctrl.md
# dvi_align_ctrl

TMDS word-alignment controller for one DVI receive channel. It watches the raw 10-bit words from the deserializer, before the data decoder, for the four TMDS control tokens. It issues single-cycle bit-slip requests to the deserializer until tokens occur at the expected rate. After that it declares lock and keeps monitoring for loss of alignment. One instance runs per channel; its `locked` output qualifies the decoder output for downstream sync and pixel logic.

## Interface
Parameters:
- `SEARCH_LEN`, 1024: window length in cycles for token counting (≥2).
- `TOKEN_MIN`, 16: minimum tokens per window for a window to count as good (1..SEARCH_LEN).
- `SETTLE_LEN`, 8: cycles ignored after each slip while the deserializer re-frames (≥1).
- `LOSS_MAX`, 4: number of consecutive bad windows in LOCKED that causes unlock (≥1).

Ports:
- `clk`  in  1  channel pixel clock, rising-edge.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `ch_in`  in  10  raw TMDS word from the deserializer.
- `en`  in  1  alignment enable; low forces IDLE.
- `bitslip`  out  1  one-cycle slip request to the deserializer.
- `locked`  out  1  alignment achieved.
- `token_det`  out  1  registered control-token match.
- `slip_cnt`  out  4  slips since last lock or reset, modulo 10.
- `err_cnt`  out  16  lock-loss count (only with `DVI_ALIGN_STAT_EN`).

## Operation
- Token match: `ch_in` equals 10'b1101010100, 10'b0010101011, 10'b0101010100 or 10'b1010101011. The result is registered into `tok_r`, and `token_det` = `tok_r`.
- States and transitions:
  - IDLE: entered when `en`=0. Counters are cleared. When `en`=1, go to SEARCH next cycle.
  - SEARCH: `win_cnt` runs 0..SEARCH_LEN-1. `tok_cnt` increments on `tok_r` and saturates at TOKEN_MIN. On the last window cycle, the count including that cycle's `tok_r` is checked: if ≥TOKEN_MIN, go to LOCKED; otherwise go to SLIP.
  - SLIP: lasts exactly 1 cycle with `bitslip`=1. `slip_cnt` <= (`slip_cnt`==9) ? 0 : `slip_cnt`+1. Go to SETTLE.
  - SETTLE: lasts SETTLE_LEN cycles. Tokens are ignored. Then go to SEARCH with `win_cnt` and `tok_cnt` cleared.
  - LOCKED: `locked`=1. Windows are counted the same way as in SEARCH.
    - A good window clears `miss_cnt`.
    - A bad window increments `miss_cnt`.
    - When `miss_cnt` reaches LOSS_MAX, go to SEARCH with counters cleared. `slip_cnt` is reset to 0 on every entry to LOCKED.
- `en`=0 in any state gives IDLE on the next cycle. `locked` and `bitslip` are deasserted that same cycle, and any pending slip is abandoned.
- Counter widths are `$clog2(max+1)`. No counter wraps except `slip_cnt` (mod 10).

## Timing
- Reset values: `bitslip`=0, `locked`=0, `token_det`=0, `slip_cnt`=0, `err_cnt`=0. The FSM resets to IDLE.
- All outputs are registered.
- `token_det` lags `ch_in` by 1 cycle.
- `locked` rises on the cycle after the final window cycle of a good SEARCH window.
- Slip period when no tokens arrive: SEARCH_LEN + 1 + SETTLE_LEN cycles.
- Unlock takes LOSS_MAX full windows of latency. `locked` falls on the cycle the FSM enters SEARCH.
- Simultaneous window end and `en` fall: `en` wins, so the next state is IDLE.

## Configuration
- `DVI_ALIGN_STAT_EN` defined:
  - `err_cnt` is present.
  - It increments (saturating at 16'hFFFF) on every LOCKED→SEARCH transition.
  - It is not cleared by `en`, only by reset.
- Undefined: the `err_cnt` port and its logic are absent. All other behaviour is identical.

## Structure
- Shared package `dvi_pkg` holds:
  - the four control-token constants (`DVI_CTL0..3`);
  - the state enum `dvi_align_st_t` {IDLE, SEARCH, SLIP, SETTLE, LOCKED}.
- Sub-module `dvi_token_det` registers `ch_in`, compares it against the package constants and produces `tok_r`. The data decoder can reuse it.

## Test plan
All scenarios use SEARCH_LEN=16, TOKEN_MIN=4, SETTLE_LEN=3, LOSS_MAX=2.
- Reset held, `ch_in` random → all outputs 0. After release with `en`=0, `locked` stays 0 and `bitslip` never pulses.
- `en`=1, `ch_in`=10'b1101010100 constant → `token_det`=1 from cycle 2. `locked`=1 after the first 16-cycle window. `bitslip` never asserted.
- `en`=1, `ch_in`=10'h000 → `bitslip` pulses every 20 cycles. `slip_cnt` goes 1..9 then 0 on the 10th pulse. `locked` stays 0.
- Window with exactly 3 tokens → `bitslip` pulse. Next window with exactly 4 tokens → `locked`=1 and `slip_cnt`=0.
- Lock, then `ch_in`=10'h000 → `locked` falls after 32 cycles. `err_cnt`=1 with `DVI_ALIGN_STAT_EN`, and the port is absent without it.
- `en` dropped during SETTLE → IDLE next cycle with no further `bitslip`. Re-raising `en` restarts SEARCH with `slip_cnt` retained.
